sdram_aref: RTL and testbench
=============================

# sdram_aref

Periodic auto-refresh engine for the SDRAM controller, placed directly downstream of `sdram_init`. Once initialization completes (`init_end`), it times the refresh interval and raises a request to the controller arbiter. On grant, it drives a PRECHARGE-ALL / AUTO-REFRESH command sequence onto the shared SDRAM command bus, then pulses a completion flag.

## Interface
Parameters:
- `CNT_REF`, 750: refresh interval in clock cycles (7.5 µs at 100 MHz, with margin under the 7.8 µs tREFI).
- `TRP`, 2: precharge-to-refresh wait, in cycles.
- `TRFC`, 7: refresh-to-next-command wait, in cycles.

Ports:
- `aref_clk` in 1: controller clock, 100 MHz.
- `aref_rst` in 1: reset, asynchronous, active-high.
- `init_end` in 1: initialization done; level signal from `sdram_init`.
- `aref_en` in 1: arbiter grant; sampled only in AREF_IDLE.
- `aref_req` out 1: refresh request to the arbiter.
- `aref_cmd` out 4: {cs_n, ras_n, cas_n, we_n}.
- `aref_bank` out 2: bank address.
- `aref_addr` out 13: address bus.
- `aref_end` out 1: one-cycle pulse when the sequence completes.

## Operation
- Command encodings: NOP = 4'b0111, PRECHARGE = 4'b0010, AUTO_REFRESH = 4'b0001.
- Interval counter `cnt_ref`:
  - Held at 0 while `init_end` = 0.
  - Otherwise increments every cycle and wraps from `CNT_REF-1` to 0.
  - Keeps running during a refresh sequence.
- `aref_req` handshake:
  - Set on the cycle after `cnt_ref` = `CNT_REF-1`.
  - Cleared on the cycle after the FSM leaves AREF_IDLE, i.e. on acceptance.
  - If a new interval expires while `aref_req` is already high, it stays high. There is no request queue.
  - If `init_end` falls, `cnt_ref` and `aref_req` clear.
- FSM states, all outputs registered:
  - AREF_IDLE: `aref_cmd` = NOP. Moves to AREF_PRE when `aref_en` && `aref_req`. `aref_en` without a pending request is ignored.
  - AREF_PRE: PRECHARGE for one cycle with `aref_addr` = 13'h0400 (A10 = 1, all banks) and `aref_bank` = 2'b11. Then moves to AREF_TRP.
  - AREF_TRP: NOP for `TRP` cycles. Then moves to AREF_AR.
  - AREF_AR: AUTO_REFRESH for one cycle; increments `cnt_ar`. Then moves to AREF_TRFC.
  - AREF_TRFC: NOP for `TRFC` cycles. Then moves to AREF_AR if `cnt_ar` < AR_NUM, otherwise to AREF_END.
  - AREF_END: NOP for one cycle with `aref_end` = 1. `cnt_ar` clears. Then moves to AREF_IDLE.
- Wait counter `cnt_clk` clears on every state change. TRP and TRFC exit when `cnt_clk` = N-1.
- `aref_en` is ignored outside AREF_IDLE.
- If `init_end` falls mid-sequence, the running sequence still completes.
- `aref_addr` = 13'h1FFF and `aref_bank` = 2'b11 in every state except AREF_PRE.

## Timing
- Reset values: `aref_cmd` = 4'b0111, `aref_bank` = 2'b11, `aref_addr` = 13'h1FFF, `aref_req` = 0, `aref_end` = 0. State = AREF_IDLE, all counters 0.
- Asserting `aref_rst` mid-sequence returns the block to reset values immediately (asynchronous). NOP is on the bus from that point.
- First `aref_req`: `CNT_REF`+1 cycles after the first cycle with `init_end` = 1.
- Grant latency: `aref_en` and `aref_req` both high at edge N gives PRECHARGE on the bus in cycle N+1.
- Sequence length: 1 + `TRP` + (1+`TRFC`)·AR_NUM + 1 cycles.
  - Defaults with AR_NUM = 2: 20 cycles.
  - AUTO_REFRESH appears at offsets 3 and 11 after PRECHARGE.
  - `aref_end` appears at offset 19.
- Request period stays `CNT_REF` cycles, independent of grant latency.

## Configuration
- `SDRAM_AREF_DOUBLE_EN` defined: AR_NUM = 2, two AUTO_REFRESH commands per sequence (20 cycles with defaults).
- Not defined: AR_NUM = 1, one AUTO_REFRESH per sequence (12 cycles; `aref_end` at offset 11).
- No other behaviour differs.

## Test plan
- Reset held 10 cycles, then released with `init_end` = 0 for 2000 cycles -> all outputs stay at reset values and `aref_req` never asserts.
- `init_end` = 1 from cycle 0 and `aref_en` tied high -> `aref_req` rises at cycle 751. PRECHARGE follows with addr 13'h0400 and bank 3, then AR at +3 and +11, then `aref_end` at +19 (macro defined). Requests repeat every 750 cycles.
- Grant withheld for 1600 cycles after the first request -> `aref_req` stays high across two interval wraps. A single sequence runs on grant, and `aref_req` clears the next cycle.
- `aref_en` pulsed while the FSM is in AREF_TRFC -> no extra command and sequence timing unchanged. `aref_en` pulsed with `aref_req` = 0 -> bus stays at NOP.
- `aref_rst` asserted during AREF_TRP -> `aref_cmd` = 4'b0111 and `aref_req` = 0 without waiting for a clock edge. After release, the first request comes `CNT_REF`+1 cycles after `init_end` is seen.
- Rebuild without `SDRAM_AREF_DOUBLE_EN` -> exactly one AUTO_REFRESH at offset 3 and `aref_end` at offset 11.

Source files
------------

// File: rtl/sdram_aref.sv
// sdram_aref: periodic auto-refresh engine sitting downstream of sdram_init.
// Latency: grant (aref_en && aref_req at an edge) puts PRECHARGE on the bus the next cycle;
//          a sequence is 1 + TRP + (1+TRFC)*AR_NUM + 1 cycles long.
// Backpressure: aref_req is held until the arbiter grants; no queue, repeated expiries merge.
// Ports: aref_clk/aref_rst (async, active-high), init_end (level), aref_en (grant, sampled in idle),
//        aref_req (request), aref_cmd {cs_n,ras_n,cas_n,we_n}, aref_bank, aref_addr, aref_end (pulse).
// Build option: define SDRAM_AREF_DOUBLE_EN for two AUTO_REFRESH commands per sequence (one otherwise).
module sdram_aref #(
    parameter int CNT_REF = 750,
    parameter int TRP     = 2,
    parameter int TRFC    = 7
) (
    input  logic        aref_clk,
    input  logic        aref_rst,
    input  logic        init_end,
    input  logic        aref_en,
    output logic        aref_req,
    output logic [3:0]  aref_cmd,
    output logic [1:0]  aref_bank,
    output logic [12:0] aref_addr,
    output logic        aref_end
);

`ifdef SDRAM_AREF_DOUBLE_EN
    localparam int AR_NUM = 2;
`else
    localparam int AR_NUM = 1;
`endif

    localparam logic [3:0]  CMD_NOP  = 4'b0111;
    localparam logic [3:0]  CMD_PRE  = 4'b0010;
    localparam logic [3:0]  CMD_AREF = 4'b0001;
    localparam logic [12:0] ADDR_IDLE = 13'h1FFF;
    localparam logic [12:0] ADDR_PALL = 13'h0400;   // A10 = 1 selects all banks

    localparam int REF_W = $clog2(CNT_REF + 1);
    localparam int CLK_W = $clog2(((TRP > TRFC) ? TRP : TRFC) + 1);

    localparam logic [REF_W-1:0] REF_LAST  = REF_W'(CNT_REF - 1);
    localparam logic [CLK_W-1:0] TRP_LAST  = CLK_W'(TRP - 1);
    localparam logic [CLK_W-1:0] TRFC_LAST = CLK_W'(TRFC - 1);
    localparam logic [1:0]       AR_LIMIT  = 2'(AR_NUM);

    typedef enum logic [2:0] {
        AREF_IDLE,
        AREF_PRE,
        AREF_TRP,
        AREF_AR,
        AREF_TRFC,
        AREF_END
    } state_t;

    state_t             state_q, state_d;
    logic [REF_W-1:0]   cnt_ref_q, cnt_ref_d;
    logic [CLK_W-1:0]   cnt_clk_q, cnt_clk_d;
    logic [1:0]         cnt_ar_q, cnt_ar_d;
    logic               req_q, req_d;
    logic [3:0]         cmd_q, cmd_d;
    logic [12:0]        addr_q, addr_d;
    logic               end_q, end_d;
    logic               accept;

    assign accept = (state_q == AREF_IDLE) && aref_en && req_q;

    // Interval timer and request flag. The timer free-runs through a sequence so
    // the request period does not stretch with grant latency. A fresh expiry wins
    // over a simultaneous acceptance so that interval is not lost.
    always_comb begin
        cnt_ref_d = '0;
        req_d     = 1'b0;
        if (init_end) begin
            cnt_ref_d = (cnt_ref_q == REF_LAST) ? '0 : cnt_ref_q + 1'b1;
            if (cnt_ref_q == REF_LAST) begin
                req_d = 1'b1;
            end else if (accept) begin
                req_d = 1'b0;
            end else begin
                req_d = req_q;
            end
        end
    end

    // Sequencer next state. Runs to completion regardless of init_end.
    always_comb begin
        state_d  = state_q;
        cnt_ar_d = cnt_ar_q;
        case (state_q)
            AREF_IDLE: if (accept) state_d = AREF_PRE;
            AREF_PRE:  state_d = AREF_TRP;
            AREF_TRP:  if (cnt_clk_q == TRP_LAST) state_d = AREF_AR;
            AREF_AR: begin
                cnt_ar_d = cnt_ar_q + 1'b1;
                state_d  = AREF_TRFC;
            end
            AREF_TRFC: begin
                if (cnt_clk_q == TRFC_LAST) begin
                    state_d = (cnt_ar_q < AR_LIMIT) ? AREF_AR : AREF_END;
                end
            end
            AREF_END: begin
                cnt_ar_d = '0;
                state_d  = AREF_IDLE;
            end
            default:   state_d = AREF_IDLE;
        endcase

        // Wait counter restarts on every state change and rests at 0 in idle.
        if ((state_d != state_q) || (state_q == AREF_IDLE)) begin
            cnt_clk_d = '0;
        end else begin
            cnt_clk_d = cnt_clk_q + 1'b1;
        end
    end

    // Outputs are decoded from the next state so the bus changes together with the state.
    always_comb begin
        cmd_d  = CMD_NOP;
        addr_d = ADDR_IDLE;
        end_d  = 1'b0;
        case (state_d)
            AREF_PRE: begin
                cmd_d  = CMD_PRE;
                addr_d = ADDR_PALL;
            end
            AREF_AR:  cmd_d = CMD_AREF;
            AREF_END: end_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge aref_clk or posedge aref_rst) begin
        if (aref_rst) begin
            state_q   <= AREF_IDLE;
            cnt_ref_q <= '0;
            cnt_clk_q <= '0;
            cnt_ar_q  <= '0;
            req_q     <= 1'b0;
            cmd_q     <= CMD_NOP;
            addr_q    <= ADDR_IDLE;
            end_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_ref_q <= cnt_ref_d;
            cnt_clk_q <= cnt_clk_d;
            cnt_ar_q  <= cnt_ar_d;
            req_q     <= req_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            end_q     <= end_d;
        end
    end

    assign aref_req  = req_q;
    assign aref_cmd  = cmd_q;
    assign aref_addr = addr_q;
    assign aref_end  = end_q;
    // Precharge-all and refresh ignore the bank bits; the bus idles at all-ones.
    assign aref_bank = 2'b11;

endmodule

// File: tb/tb_sdram_aref.sv
// tb_sdram_aref: self-checking bench for sdram_aref with a cycle-level reference model.
// Latency: checks every cycle, 1 time unit after the rising edge.
// Backpressure: exercises withheld, ignored and out-of-state grants.
module tb_sdram_aref;

    localparam int CNT_REF = 750;
    localparam int TRP     = 2;
    localparam int TRFC    = 7;
`ifdef SDRAM_AREF_DOUBLE_EN
    localparam int AR_NUM  = 2;
`else
    localparam int AR_NUM  = 1;
`endif
    localparam int SEQ_LEN = 1 + TRP + (1 + TRFC) * AR_NUM + 1;
    localparam int N_ROWS  = SEQ_LEN + 2;

    localparam logic [3:0] NOP  = 4'b0111;
    localparam logic [3:0] PRE  = 4'b0010;
    localparam logic [3:0] AREF = 4'b0001;
    localparam logic [20:0] RST_VEC = {NOP, 2'b11, 13'h1FFF, 1'b0, 1'b0};

    logic        clk;
    logic        rst;
    logic        ie;
    logic        en;
    logic        aref_req;
    logic [3:0]  aref_cmd;
    logic [1:0]  aref_bank;
    logic [12:0] aref_addr;
    logic        aref_end;

    int n_tests;
    int n_fail;

    // Reference model: cycles since init_end, pending flag, and offset into a running sequence.
    int m_tick;
    bit m_req;
    bit m_busy;
    int m_off;

    typedef struct {
        string       name;
        bit          en;
        logic [3:0]  cmd;
        logic [12:0] addr;
        bit          req;
        bit          fin;
    } vec_t;

    vec_t tbl [N_ROWS];

    sdram_aref #(.CNT_REF(CNT_REF), .TRP(TRP), .TRFC(TRFC)) dut (
        .aref_clk  (clk),
        .aref_rst  (rst),
        .init_end  (ie),
        .aref_en   (en),
        .aref_req  (aref_req),
        .aref_cmd  (aref_cmd),
        .aref_bank (aref_bank),
        .aref_addr (aref_addr),
        .aref_end  (aref_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [20:0] dut_out();
        return {aref_cmd, aref_bank, aref_addr, aref_req, aref_end};
    endfunction

    function automatic logic [20:0] model_out();
        logic [3:0]  c;
        logic [12:0] a;
        logic        e;
        c = NOP;
        a = 13'h1FFF;
        e = 1'b0;
        if (m_busy) begin
            if (m_off == 0) begin
                c = PRE;
                a = 13'h0400;
            end else if (m_off == SEQ_LEN - 1) begin
                e = 1'b1;
            end else if (m_off >= 1 + TRP && ((m_off - 1 - TRP) % (1 + TRFC)) == 0) begin
                c = AREF;
            end
        end
        return {c, 2'b11, a, m_req, e};
    endfunction

    task automatic model_reset();
        m_tick = 0;
        m_req  = 1'b0;
        m_busy = 1'b0;
        m_off  = 0;
    endtask

    task automatic model_step();
        bit acc;
        acc = !m_busy && en && m_req;
        if (m_busy) begin
            m_off++;
            if (m_off == SEQ_LEN) m_busy = 1'b0;
        end
        if (acc) begin
            m_busy = 1'b1;
            m_off  = 0;
        end
        if (!ie) begin
            m_tick = 0;
            m_req  = 1'b0;
        end else begin
            if (m_tick == CNT_REF - 1) m_req = 1'b1;
            else if (acc)              m_req = 1'b0;
            m_tick = (m_tick + 1) % CNT_REF;
        end
    endtask

    task automatic check(input string name, input logic [20:0] got, input logic [20:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s @%0t: got {cmd,bank,addr,req,end}=%h want %h", name, $time, got, want);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        #1;
        check("model", dut_out(), model_out());
    endtask

    // Ticks until aref_req is seen high, bounded by limit.
    task automatic wait_req(output int n, input int limit);
        n = 0;
        while (!aref_req && n < limit) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen;
        int low_seen;
        int end_off;
        int ar_offs[$];

        n_tests = 0;
        n_fail  = 0;

        // Grant table for one sequence, row i = offset i after PRECHARGE.
        for (int i = 0; i < N_ROWS; i++) begin
            tbl[i].name = "seq_nop";
            tbl[i].en   = 1'b0;
            tbl[i].cmd  = NOP;
            tbl[i].addr = 13'h1FFF;
            tbl[i].req  = 1'b0;
            tbl[i].fin  = 1'b0;
        end
        tbl[0].name = "seq_pre";  tbl[0].cmd = PRE; tbl[0].addr = 13'h0400;
        tbl[3].name = "seq_ar1";  tbl[3].cmd = AREF;
        tbl[6].name = "seq_trfc_en"; tbl[6].en = 1'b1;   // grant inside TRFC is ignored
`ifdef SDRAM_AREF_DOUBLE_EN
        tbl[11].name = "seq_ar2"; tbl[11].cmd = AREF;
        tbl[19].name = "seq_end"; tbl[19].fin = 1'b1;
        tbl[20].name = "idle_en_noreq"; tbl[20].en = 1'b1;
`else
        tbl[11].name = "seq_end"; tbl[11].fin = 1'b1;
        tbl[12].name = "idle_en_noreq"; tbl[12].en = 1'b1;
`endif

        // Reset held 10 cycles.
        rst = 1'b1;
        ie  = 1'b0;
        en  = 1'b0;
        model_reset();
        repeat (10) tick();
        check("reset_state", dut_out(), RST_VEC);
        rst = 1'b0;

        // init_end low: nothing happens whatever the grant does.
        seen = 0;
        for (int i = 0; i < 2000; i++) begin
            en = 1'($urandom_range(0, 1));
            tick();
            if (aref_req || aref_cmd != NOP) seen = 1;
        end
        check_int("idle_without_init", seen, 0);
        check("idle_outputs", dut_out(), RST_VEC);

        // init_end high with grant tied high. Cycle 1 is the first cycle with init_end = 1.
        ie = 1'b1;
        en = 1'b1;
        wait_req(n, 2000);
        check_int("first_req_cycle", n + 1, CNT_REF + 1);
        tick();
        check("grant_pre", dut_out(), {PRE, 2'b11, 13'h0400, 1'b0, 1'b0});
        end_off = -1;
        for (int o = 1; o <= SEQ_LEN; o++) begin
            tick();
            if (aref_cmd == AREF) ar_offs.push_back(o);
            if (aref_end) end_off = o;
        end
        check_int("ar_count", ar_offs.size(), AR_NUM);
        check_int("ar_off_first", (ar_offs.size() > 0) ? ar_offs[0] : -1, 3);
`ifdef SDRAM_AREF_DOUBLE_EN
        check_int("ar_off_second", (ar_offs.size() > 1) ? ar_offs[1] : -1, 11);
        check_int("end_offset", end_off, 19);
`else
        check_int("end_offset", end_off, 11);
`endif
        wait_req(n, 1000);
        check_int("req_period_1", 1 + SEQ_LEN + n, CNT_REF);
        tick();
        wait_req(n, 1000);
        check_int("req_period_2", 1 + n, CNT_REF);

        // Grant withheld across two interval wraps.
        en = 1'b0;
        low_seen = 0;
        for (int i = 0; i < 1600; i++) begin
            tick();
            if (!aref_req) low_seen = 1;
        end
        check_int("req_held", low_seen, 0);
        en = 1'b1;
        tick();
        for (int i = 0; i < N_ROWS; i++) begin
            check(tbl[i].name, dut_out(),
                  {tbl[i].cmd, 2'b11, tbl[i].addr, 1'(tbl[i].req), 1'(tbl[i].fin)});
            en = tbl[i].en;
            tick();
        end
        en = 1'b0;

        // Asynchronous reset during TRP.
        wait_req(n, 1000);
        check("req_pending", {20'h0, aref_req}, 21'h1);
        en = 1'b1;
        tick();
        en = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("rst_in_trp", dut_out(), RST_VEC);
        tick();
        tick();
        rst = 1'b0;
        wait_req(n, 2000);
        check_int("req_after_rst", n + 1, CNT_REF + 1);

        // Asynchronous reset with a request pending, then during AUTO_REFRESH.
        #2;
        rst = 1'b1;
        #1;
        check("rst_req_pending", dut_out(), RST_VEC);
        tick();
        rst = 1'b0;
        wait_req(n, 2000);
        en = 1'b1;
        tick();
        en = 1'b0;
        repeat (3) tick();
        check("ar_before_rst", {aref_cmd, 17'h0}, {AREF, 17'h0});
        #2;
        rst = 1'b1;
        #1;
        check("rst_in_ar", dut_out(), RST_VEC);
        tick();
        rst = 1'b0;

        // Randomized grants and occasional init_end drops against the model.
        for (int i = 0; i < 4000; i++) begin
            en = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 599) == 0) ie = ~ie;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
